// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and defaults for the stopwatch control slice.
//   state_t         - FSM state encoding (IDLE=00, RUN=01, PAUSE=10; 11 unused)
//   DEF_DIV         - default clock cycles per tick
//   DEF_SYNC_STAGES - default button synchronizer depth
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  localparam int unsigned DEF_DIV         = 10;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: SYNC_STAGES-deep synchronizer followed by a rising-edge
// detector. A held button produces exactly one single-cycle pulse.
// Ports:
//   clk   in  clock
//   rst   in  asynchronous active-high reset
//   btn   in  raw asynchronous button level
//   pulse out one-cycle pulse on a synchronized rising edge (combinational)
module btn_sync_edge
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign pulse = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run control for the downstream decade counters.
// Turns raw start/stop and clear buttons into a run/pause FSM, a tick
// count-enable every DIV cycles while running, and a counter-clear pulse.
// Optional lap feature enabled by defining STOPWATCH_LAP_EN.
// Ports:
//   clk            in  clock
//   rst            in  asynchronous active-high reset
//   btn_start_stop in  raw button, rising edge toggles run/pause
//   btn_clear      in  raw button, rising edge clears
//   btn_lap        in  raw button, rising edge in RUN toggles lap_hold (STOPWATCH_LAP_EN)
//   tick           out registered one-cycle count enable
//   cnt_clr        out registered one-cycle counter clear
//   running        out registered, high while in RUN
//   state          out current FSM state
//   lap_hold       out display-freeze flag (STOPWATCH_LAP_EN)
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV         = DEF_DIV,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       btn_lap,
  output logic       lap_hold,
`endif
  output logic       tick,
  output logic       cnt_clr,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned   PW         = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic          ss_p;
  logic          clr_p;
  state_t        state_q, state_n;
  logic [PW-1:0] presc_q, presc_n;
  logic          tick_n, clr_n;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_start_stop),
    .pulse (ss_p)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clear),
    .pulse (clr_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      tick    <= 1'b0;
      cnt_clr <= 1'b0;
      running <= 1'b0;
    end else begin
      state_q <= state_n;
      presc_q <= presc_n;
      tick    <= tick_n;
      cnt_clr <= clr_n;
      running <= (state_n == ST_RUN);
    end
  end

  // The prescaler does not advance on a start/stop edge, so pausing on a
  // wrap edge leaves it at DIV-1 and the wrap fires on the first edge
  // after resume.
  always_comb begin
    state_n = state_q;
    presc_n = presc_q;
    tick_n  = 1'b0;
    clr_n   = 1'b0;
    if (clr_p) begin
      state_n = ST_IDLE;
      presc_n = '0;
      clr_n   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_n = '0;
          if (ss_p) state_n = ST_RUN;
        end
        ST_RUN: begin
          if (ss_p) begin
            state_n = ST_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_n = '0;
            tick_n  = 1'b1;
          end else begin
            presc_n = presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (ss_p) state_n = ST_RUN;
        end
        default: begin
          state_n = ST_IDLE;
          presc_n = '0;
        end
      endcase
    end
  end

  assign state = state_q;

`ifdef STOPWATCH_LAP_EN
  logic lap_p;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lap (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_lap),
    .pulse (lap_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_hold <= 1'b0;
    end else if (clr_p) begin
      lap_hold <= 1'b0;
    end else if (lap_p && state_q == ST_RUN) begin
      lap_hold <= ~lap_hold;
    end
  end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: self-checking bench for stopwatch_ctrl with DIV=4.
// A behavioural model (button history queues + mode/phase arithmetic) is
// compared against the DUT every cycle; directed scenarios pin latencies
// and counts with literal expectations.
module tb_stopwatch_ctrl;

  localparam int unsigned DIV = 4;
  localparam int unsigned SS  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_clr = 1'b0;
  logic       tick, cnt_clr, running;
  logic [1:0] state;
`ifdef STOPWATCH_LAP_EN
  logic       btn_lap = 1'b0;
  logic       lap_hold;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  stopwatch_ctrl #(.DIV(DIV), .SYNC_STAGES(SS)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start_stop (btn_ss),
    .btn_clear      (btn_clr),
`ifdef STOPWATCH_LAP_EN
    .btn_lap        (btn_lap),
    .lap_hold       (lap_hold),
`endif
    .tick           (tick),
    .cnt_clr        (cnt_clr),
    .running        (running),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Button level history, newest first; a pulse is seen SS edges after the
  // level first samples high.
  bit q_ss[$], q_clr[$];
  int m_mode;   // 0 idle, 1 run, 2 pause
  int m_phase;  // cycles counted toward the next tick
  int m_tick, m_clr, m_run;
  bit ps, pc;
`ifdef STOPWATCH_LAP_EN
  bit q_lap[$];
  bit pl;
  int m_lap;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_ss.delete(); q_clr.delete();
      for (int i = 0; i <= SS; i++) begin q_ss.push_back(1'b0); q_clr.push_back(1'b0); end
      m_mode = 0; m_phase = 0; m_tick = 0; m_clr = 0; m_run = 0;
`ifdef STOPWATCH_LAP_EN
      q_lap.delete();
      for (int i = 0; i <= SS; i++) q_lap.push_back(1'b0);
      m_lap = 0;
`endif
    end else begin
      ps = q_ss[SS-1] && !q_ss[SS];
      pc = q_clr[SS-1] && !q_clr[SS];
      q_ss.push_front(btn_ss);   void'(q_ss.pop_back());
      q_clr.push_front(btn_clr); void'(q_clr.pop_back());
`ifdef STOPWATCH_LAP_EN
      pl = q_lap[SS-1] && !q_lap[SS];
      q_lap.push_front(btn_lap); void'(q_lap.pop_back());
      if (pc) m_lap = 0;
      else if (pl && m_mode == 1) m_lap = 1 - m_lap;
`endif
      m_tick = 0;
      m_clr  = 0;
      if (pc) begin
        m_mode = 0; m_phase = 0; m_clr = 1;
      end else if (m_mode == 1) begin
        if (ps) m_mode = 2;
        else begin
          m_phase = m_phase + 1;
          if (m_phase == DIV) begin m_phase = 0; m_tick = 1; end
        end
      end else if (m_mode == 2) begin
        if (ps) m_mode = 1;
      end else begin
        m_phase = 0;
        if (ps) m_mode = 1;
      end
      m_run = (m_mode == 1) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_state", state, m_mode);
      chk("model_running", running, m_run);
      chk("model_tick", tick, m_tick);
      chk("model_cnt_clr", cnt_clr, m_clr);
`ifdef STOPWATCH_LAP_EN
      chk("model_lap_hold", lap_hold, m_lap);
`endif
    end
  end

  // ---------------- directed helpers ----------------
  function automatic int cur(input int which);
    case (which)
      0: return int'(running);
      1: return int'(state);
      2: return int'(tick);
      3: return int'(cnt_clr);
`ifdef STOPWATCH_LAP_EN
      4: return int'(lap_hold);
`endif
      default: return -1;
    endcase
  endfunction

  // Edges until the selected output equals val; 99 if it never does.
  task automatic wait_sig(input int which, input int val, output int n);
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (cur(which) == val) begin n = i; return; end
    end
    n = 99;
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  int n, cnt, first, rises;
  logic prev_run;

  initial begin
    // reset
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_running", running, 0);
    chk("reset_tick", tick, 0);
    chk("reset_cnt_clr", cnt_clr, 0);

    // start latency, first tick, tick count
    #1 btn_ss = 1'b1;
    wait_sig(0, 1, n);
    chk("start_latency", n, 3);
    btn_ss = 1'b0;
    cnt = 0; first = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (tick === 1'b1) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    chk("first_tick_delay", first, 4);
    chk("ticks_in_40", cnt, 10);

    // pause with prescaler at 2, then resume
    btn_ss = 1'b1;
    wait_sig(1, 2, n);
    chk("pause_latency", n, 3);
    btn_ss = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tick === 1'b1) cnt++;
    end
    chk("pause_ticks", cnt, 0);
    chk("pause_hold_state", state, 2);
    btn_ss = 1'b1;
    wait_sig(0, 1, n);
    chk("resume_latency", n, 3);
    btn_ss = 1'b0;
    wait_sig(2, 1, n);
    chk("resume_tick_delay", n, 2);

    // start/stop landing on the wrap edge beats the wrap
    step(1);
    btn_ss = 1'b1;
    wait_sig(1, 2, n);
    chk("wrap_pause_latency", n, 3);
    chk("wrap_pause_no_tick", tick, 0);
    btn_ss = 1'b0;
    step(5);
    btn_ss = 1'b1;
    wait_sig(0, 1, n);
    chk("wrap_resume_latency", n, 3);
    btn_ss = 1'b0;
    step(1);
    chk("wrap_after_resume", tick, 1);

    // clear and start/stop together during RUN
    step(3);
    btn_ss = 1'b1; btn_clr = 1'b1;
    wait_sig(1, 0, n);
    chk("clr_latency", n, 3);
    chk("clr_pulse", cnt_clr, 1);
    chk("clr_tick", tick, 0);
    chk("clr_running", running, 0);
    step(1);
    chk("clr_one_cycle", cnt_clr, 0);
    chk("clr_beats_start", state, 0);
    btn_ss = 1'b0; btn_clr = 1'b0;

    // clear while already idle still pulses
    step(3);
    btn_clr = 1'b1;
    wait_sig(3, 1, n);
    chk("idle_clr_latency", n, 3);
    chk("idle_clr_state", state, 0);
    step(1);
    chk("idle_clr_one_cycle", cnt_clr, 0);
    btn_clr = 1'b0;

    // held start/stop gives one transition
    step(3);
    btn_ss = 1'b1;
    rises = 0; prev_run = running;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (running === 1'b1 && prev_run === 1'b0) rises++;
      prev_run = running;
    end
    chk("held_rises", rises, 1);
    chk("held_state", state, 1);
    btn_ss = 1'b0;
    step(2);
    btn_ss = 1'b1;
    wait_sig(1, 2, n);
    chk("repress_pause", n, 3);
    btn_ss = 1'b0;

    // asynchronous reset mid-RUN
    step(2);
    btn_ss = 1'b1;
    wait_sig(0, 1, n);
    chk("pre_reset_run", n, 3);
    btn_ss = 1'b0;
    step(5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_tick", tick, 0);
    chk("async_rst_cnt_clr", cnt_clr, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tick === 1'b1) cnt++;
    end
    chk("post_rst_ticks", cnt, 0);
    chk("post_rst_state", state, 0);

`ifdef STOPWATCH_LAP_EN
    btn_ss = 1'b1;
    wait_sig(0, 1, n);
    chk("lap_run", n, 3);
    btn_ss = 1'b0;
    btn_lap = 1'b1;
    wait_sig(4, 1, n);
    chk("lap_set", n, 3);
    btn_lap = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (tick === 1'b1) cnt++;
    end
    chk("lap_ticks_continue", cnt, 2);
    btn_lap = 1'b1;
    wait_sig(4, 0, n);
    chk("lap_toggle_off", n, 3);
    btn_lap = 1'b0;
    step(2);
    btn_lap = 1'b1;
    wait_sig(4, 1, n);
    chk("lap_toggle_on", n, 3);
    btn_lap = 1'b0;
    btn_ss = 1'b1;
    wait_sig(1, 2, n);
    chk("lap_pause", n, 3);
    btn_ss = 1'b0;
    btn_lap = 1'b1;
    step(6);
    chk("lap_pause_ignored", lap_hold, 1);
    btn_lap = 1'b0;
    btn_clr = 1'b1;
    wait_sig(4, 0, n);
    chk("lap_clear", n, 3);
    btn_clr = 1'b0;
    step(3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
